load_size_ctrl: RTL and testbench
=================================

# load_size_ctrl

Sequential load path for the multicycle CPU: on a start pulse it issues one memory read, waits a fixed memory latency, and captures the returned word into an internal MDR. It then extracts a byte, halfword or word from the low bits and extends it to 32 bits for register write-back. It is the read-side counterpart of the store-size merge unit. Its raw MDR word (`mdrOut`) feeds that unit for sub-word stores.

## Interface
Parameters:
- `MEM_LATENCY`, default 1: cycles from `memRead` strobe to valid `memData`. Legal range 1–15.
- `CNT_W`, default 4: width of the latency counter. Must satisfy 2^CNT_W > MEM_LATENCY.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting low clears all state immediately.
- `start`  in  1  load request; sampled only in IDLE.
- `loadSel`  in  2  load size:
  - 00 byte
  - 01 halfword
  - 10 word
  - 11 treated as word
- `addr`  in  32  load address; passed through unchanged.
- `memData`  in  32  memory read data; valid in the last WAIT cycle.
- `memRead`  out  1  memory read strobe; one cycle per load.
- `memAddr`  out  32  latched address; stable from REQ through DONE.
- `mdrOut`  out  32  raw captured word.
- `lsOut`  out  32  size-formatted, extended load result.
- `busy`  out  1  high when the state is not IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If `start`=1, latch `addr` and `loadSel`, then go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - Drive `memRead`=1 for this cycle only.
  - Load the counter with MEM_LATENCY−1.
  - Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, register `memData` into the MDR and the formatted result into `lsOut`, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Formatting always uses the low bits, matching the store side; there is no lane select by `addr[1:0]`:
  - byte: bits [7:0] extended to 32.
  - halfword: bits [15:0] extended to 32.
  - word: all 32 bits.
- `start` in REQ, WAIT or DONE is ignored, not queued.
- Changes on `addr` or `loadSel` after the start edge have no effect on the load in progress.
- `mdrOut` and `lsOut` hold their values until the next capture.

## Timing
- Reset values, applied asynchronously:
  - state IDLE
  - `memRead`=0, `busy`=0, `done`=0
  - `memAddr`, `mdrOut`, `lsOut` = 0
  - counter = 0
- Cycle sequence, with start sampled at edge 0:
  - REQ occupies cycle 1.
  - WAIT occupies cycles 2 .. MEM_LATENCY+1.
  - `done` is high in cycle MEM_LATENCY+2.
  - With MEM_LATENCY=1: `memRead` in cycle 1, `memData` sampled at the end of cycle 2, `done` in cycle 3.
- `lsOut` and `mdrOut` change on the same edge that raises `done`.
- Throughput: the next `start` is accepted in the first IDLE cycle after DONE, giving one load per MEM_LATENCY+3 cycles.
- Reset asserted mid-operation: the load is abandoned. Outputs go to their reset values with no further `memRead` or `done`.
- Counter behaviour: decrements only in WAIT. It never wraps, because the exit is taken at 0.

## Configuration
- Macro `LOAD_SIGN_EXTEND_EN`.
- Defined: byte and halfword results are sign-extended from bit 7 and bit 15 respectively.
- Undefined: byte and halfword results are zero-extended.
- Word loads are unaffected in both cases.

## Structure
- Shared package `cpu_mem_pkg` holds:
  - the `loadSel` encodings (LS_BYTE, LS_HALF, LS_WORD), also used by the store-size unit;
  - the FSM state enum.
- Sub-module `load_extend` is combinational. It takes the word, size and a signed flag, and returns the 32-bit result. The FSM registers its output on capture.

## Test plan
- Word load, MEM_LATENCY=1: start with `addr`=0x100, `loadSel`=10, `memData`=0xDEADBEEF.
  - `memRead` high in cycle 1 with `memAddr`=0x100.
  - `done` in cycle 3 with `lsOut`=`mdrOut`=0xDEADBEEF.
- Byte load of `memData`=0x123456F0:
  - With `LOAD_SIGN_EXTEND_EN`: `lsOut`=0xFFFFFFF0.
  - Without it: `lsOut`=0x000000F0.
  - `mdrOut`=0x123456F0 in both cases.
- Halfword load of 0x0000_8001 with sign extension: `lsOut`=0xFFFF8001. Of 0xABCD_7FFF: `lsOut`=0x00007FFF.
- MEM_LATENCY=4:
  - `done` exactly 6 cycles after the start edge.
  - `start` pulsed during WAIT produces no second `memRead`.
  - `busy` is high for cycles 1–6.
- Reset low during WAIT:
  - `busy`, `memRead`, `done`, `lsOut` are 0 immediately.
  - After release, no `done` appears until a new `start`.
- `loadSel`=11 with `memData`=0x80000000: `lsOut`=0x80000000.
- Changing `addr` mid-load leaves `memAddr` at the latched value.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared memory-path definitions: load/store size encodings and the load FSM state type.
package cpu_mem_pkg;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter: picks byte/halfword/word from the low bits and extends to 32.
module load_extend
  import cpu_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = word_i;
    case (size_i)
      LS_BYTE: result_o = {{24{sign_i & word_i[7]}}, word_i[7:0]};
      LS_HALF: result_o = {{16{sign_i & word_i[15]}}, word_i[15:0]};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_size_ctrl.sv
// Multicycle load sequencer: one memory read per start, fixed latency, MDR capture and extension.
// Build option LOAD_SIGN_EXTEND_EN selects sign extension of byte/halfword results (zero-extend otherwise).
module load_size_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  loadSel,
  input  logic [31:0] addr,
  input  logic [31:0] memData,
  output logic        memRead,
  output logic [31:0] memAddr,
  output logic [31:0] mdrOut,
  output logic [31:0] lsOut,
  output logic        busy,
  output logic        done,
  output state_e      dbg_state
);

`ifdef LOAD_SIGN_EXTEND_EN
  localparam logic SIGN_EXT = 1'b1;
`else
  localparam logic SIGN_EXT = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        sel_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       mdr_q;
  logic [31:0]       ls_q;
  logic              mem_read_q;
  logic              busy_q;
  logic              done_q;
  logic [31:0]       ext_word;

  load_extend u_extend (
    .word_i   (memData),
    .size_i   (sel_q),
    .sign_i   (SIGN_EXT),
    .result_o (ext_word)
  );

  // Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse
  // coincident with lsOut/mdrOut updating; memRead is a one-cycle strobe in REQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sel_q      <= LS_BYTE;
      mem_addr_q <= '0;
      mdr_q      <= '0;
      ls_q       <= '0;
      mem_read_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mem_read_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mem_addr_q <= addr;
            sel_q      <= loadSel;
            mem_read_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          cnt_q   <= CNT_LOAD;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // Exit is taken at zero, so the counter never wraps.
          if (cnt_q == '0) begin
            mdr_q   <= memData;
            ls_q    <= ext_word;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign memRead   = mem_read_q;
  assign memAddr   = mem_addr_q;
  assign mdrOut    = mdr_q;
  assign lsOut     = ls_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_load_size_ctrl.sv
// Directed bench for load_size_ctrl: instance a uses MEM_LATENCY=1, instance b uses MEM_LATENCY=4.
module tb_load_size_ctrl;
  import cpu_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start_a = 1'b0, start_b = 1'b0;
  logic [1:0]  sel_a = 2'b00, sel_b = 2'b00;
  logic [31:0] addr_a = '0, addr_b = '0;
  logic [31:0] mem_a = '0, mem_b = '0;

  logic        rd_a, rd_b, busy_a, busy_b, done_a, done_b;
  logic [31:0] maddr_a, maddr_b, mdr_a, mdr_b, ls_a, ls_b;
  state_e      st_a, st_b;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef LOAD_SIGN_EXTEND_EN
  localparam bit SEXT = 1'b1;
`else
  localparam bit SEXT = 1'b0;
`endif

  load_size_ctrl #(.MEM_LATENCY(1), .CNT_W(4)) dut_a (
    .clk(clk), .reset(rst_n), .start(start_a), .loadSel(sel_a), .addr(addr_a),
    .memData(mem_a), .memRead(rd_a), .memAddr(maddr_a), .mdrOut(mdr_a),
    .lsOut(ls_a), .busy(busy_a), .done(done_a), .dbg_state(st_a)
  );

  load_size_ctrl #(.MEM_LATENCY(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(rst_n), .start(start_b), .loadSel(sel_b), .addr(addr_b),
    .memData(mem_b), .memRead(rd_b), .memAddr(maddr_b), .mdrOut(mdr_b),
    .lsOut(ls_b), .busy(busy_b), .done(done_b), .dbg_state(st_b)
  );

  always #5 clk = ~clk;

  // Driver: called at a negedge in IDLE; returns the cycle (after the start edge) in which done was seen, or -1.
  task automatic run_a(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d, output int cyc);
    addr_a = a; sel_a = s; mem_a = d; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 1;
    while (done_a !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (done_a !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({rd_a, busy_a, done_a, maddr_a, mdr_a, ls_a} !== 99'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs_a: got rd=%b busy=%b done=%b maddr=%h mdr=%h ls=%h, want all 0",
               rd_a, busy_a, done_a, maddr_a, mdr_a, ls_a);
    end
    tests_run++;
    if (st_a !== ST_IDLE || st_b !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got a=%0d b=%0d, want 0", st_a, st_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word();
    @(negedge clk);
    addr_a = 32'h100; sel_a = 2'b10; mem_a = 32'hDEADBEEF; start_a = 1'b1;
    @(negedge clk); // cycle 1
    start_a = 1'b0;
    tests_run++;
    if (rd_a !== 1'b1 || maddr_a !== 32'h100 || busy_a !== 1'b1 || done_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL word_cycle1: got rd=%b maddr=%h busy=%b done=%b, want rd=1 maddr=100 busy=1 done=0",
               rd_a, maddr_a, busy_a, done_a);
    end
    @(negedge clk); // cycle 2
    tests_run++;
    if (rd_a !== 1'b0 || done_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL word_cycle2: got rd=%b done=%b, want 0 0", rd_a, done_a);
    end
    @(negedge clk); // cycle 3
    tests_run++;
    if (done_a !== 1'b1 || ls_a !== 32'hDEADBEEF || mdr_a !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL word_cycle3: got done=%b ls=%h mdr=%h, want 1 deadbeef deadbeef", done_a, ls_a, mdr_a);
    end
    @(negedge clk); // cycle 4
    tests_run++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || ls_a !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL word_cycle4: got done=%b busy=%b ls=%h, want 0 0 deadbeef", done_a, busy_a, ls_a);
    end
  endtask

  task automatic test_extend();
    int cyc;
    logic [31:0] exp;
    @(negedge clk);
    run_a(32'h200, 2'b00, 32'h123456F0, cyc);
    exp = SEXT ? 32'hFFFFFFF0 : 32'h000000F0;
    tests_run++;
    if (cyc !== 3 || ls_a !== exp || mdr_a !== 32'h123456F0) begin
      tests_failed++;
      $display("FAIL byte_load: got cyc=%0d ls=%h mdr=%h, want cyc=3 ls=%h mdr=123456f0", cyc, ls_a, mdr_a, exp);
    end
    @(negedge clk);
    run_a(32'h204, 2'b01, 32'h00008001, cyc);
    exp = SEXT ? 32'hFFFF8001 : 32'h00008001;
    tests_run++;
    if (cyc !== 3 || ls_a !== exp) begin
      tests_failed++;
      $display("FAIL half_neg: got cyc=%0d ls=%h, want cyc=3 ls=%h", cyc, ls_a, exp);
    end
    @(negedge clk);
    run_a(32'h208, 2'b01, 32'hABCD7FFF, cyc);
    tests_run++;
    if (cyc !== 3 || ls_a !== 32'h00007FFF || mdr_a !== 32'hABCD7FFF) begin
      tests_failed++;
      $display("FAIL half_pos: got cyc=%0d ls=%h mdr=%h, want cyc=3 ls=00007fff mdr=abcd7fff", cyc, ls_a, mdr_a);
    end
    @(negedge clk);
    run_a(32'h20C, 2'b11, 32'h80000000, cyc);
    tests_run++;
    if (cyc !== 3 || ls_a !== 32'h80000000) begin
      tests_failed++;
      $display("FAIL sel11_word: got cyc=%0d ls=%h, want cyc=3 ls=80000000", cyc, ls_a);
    end
    @(negedge clk);
    run_a(32'h210, 2'b00, 32'hFFFFFF7F, cyc);
    tests_run++;
    if (cyc !== 3 || ls_a !== 32'h0000007F) begin
      tests_failed++;
      $display("FAIL byte_pos: got cyc=%0d ls=%h, want cyc=3 ls=0000007f", cyc, ls_a);
    end
  endtask

  task automatic test_input_change();
    int cyc;
    int bad_addr;
    @(negedge clk);
    addr_a = 32'h300; sel_a = 2'b00; mem_a = 32'h11223344; start_a = 1'b1;
    @(negedge clk); // cycle 1: disturb the inputs after the start edge
    start_a = 1'b0; addr_a = 32'h0000FFFF; sel_a = 2'b10;
    bad_addr = 0;
    cyc = 1;
    while (done_a !== 1'b1 && cyc < 20) begin
      if (maddr_a !== 32'h300) bad_addr++;
      @(negedge clk);
      cyc++;
    end
    if (maddr_a !== 32'h300) bad_addr++;
    tests_run++;
    if (bad_addr != 0 || cyc !== 3) begin
      tests_failed++;
      $display("FAIL addr_hold: got %0d bad cycles maddr=%h cyc=%0d, want 0 bad maddr=300 cyc=3", bad_addr, maddr_a, cyc);
    end
    tests_run++;
    if (ls_a !== 32'h00000044) begin
      tests_failed++;
      $display("FAIL sel_hold: got ls=%h, want 00000044", ls_a);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    run_a(32'h400, 2'b10, 32'h0BADF00D, cyc);
    @(negedge clk); // first IDLE cycle after DONE
    tests_run++;
    if (busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle: got busy=%b, want 0", busy_a);
    end
    run_a(32'h404, 2'b10, 32'h5A5A5A5A, cyc);
    tests_run++;
    if (cyc !== 3 || ls_a !== 32'h5A5A5A5A || maddr_a !== 32'h404) begin
      tests_failed++;
      $display("FAIL b2b_second: got cyc=%0d ls=%h maddr=%h, want 3 5a5a5a5a 404", cyc, ls_a, maddr_a);
    end
  endtask

  task automatic test_latency4();
    int rd_cnt, done_cnt, done_cyc, busy_bad;
    @(negedge clk);
    addr_b = 32'h500; sel_b = 2'b10; mem_b = 32'hCAFE0001; start_b = 1'b1;
    rd_cnt = 0; done_cnt = 0; done_cyc = -1; busy_bad = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start_b = (c == 3); // pulse during WAIT, must be ignored
      if (rd_b === 1'b1) rd_cnt++;
      if (done_b === 1'b1) begin done_cnt++; done_cyc = c; end
      if (busy_b !== ((c >= 1 && c <= 6) ? 1'b1 : 1'b0)) busy_bad++;
    end
    start_b = 1'b0;
    tests_run++;
    if (done_cnt != 1 || done_cyc != 6) begin
      tests_failed++;
      $display("FAIL lat4_done: got count=%0d cycle=%0d, want count=1 cycle=6", done_cnt, done_cyc);
    end
    tests_run++;
    if (rd_cnt != 1) begin
      tests_failed++;
      $display("FAIL lat4_memread: got %0d strobes, want 1", rd_cnt);
    end
    tests_run++;
    if (busy_bad != 0) begin
      tests_failed++;
      $display("FAIL lat4_busy: got %0d wrong cycles, want 0", busy_bad);
    end
    tests_run++;
    if (ls_b !== 32'hCAFE0001 || mdr_b !== 32'hCAFE0001) begin
      tests_failed++;
      $display("FAIL lat4_data: got ls=%h mdr=%h, want cafe0001 cafe0001", ls_b, mdr_b);
    end
  endtask

  task automatic test_reset_mid();
    int stray, done_cyc;
    @(negedge clk);
    addr_b = 32'h600; sel_b = 2'b10; mem_b = 32'h77777777; start_b = 1'b1;
    @(negedge clk); // cycle 1
    start_b = 1'b0;
    @(negedge clk); // cycle 2 (WAIT)
    @(negedge clk); // cycle 3 (WAIT)
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy_b !== 1'b0 || rd_b !== 1'b0 || done_b !== 1'b0 || ls_b !== 32'h0 || st_b !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_mid: got busy=%b rd=%b done=%b ls=%h st=%0d, want all 0",
               busy_b, rd_b, done_b, ls_b, st_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done_b === 1'b1 || rd_b === 1'b1 || busy_b === 1'b1) stray++;
    end
    tests_run++;
    if (stray != 0) begin
      tests_failed++;
      $display("FAIL reset_no_resume: got %0d active cycles, want 0", stray);
    end
    start_b = 1'b1; sel_b = 2'b00; mem_b = 32'h00000080;
    done_cyc = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (done_b === 1'b1 && done_cyc < 0) done_cyc = c;
    end
    tests_run++;
    if (done_cyc != 6 || ls_b !== (SEXT ? 32'hFFFFFF80 : 32'h00000080)) begin
      tests_failed++;
      $display("FAIL reset_reload: got cycle=%0d ls=%h, want cycle=6 ls=%h",
               done_cyc, ls_b, SEXT ? 32'hFFFFFF80 : 32'h00000080);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_extend();
    test_input_change();
    test_back_to_back();
    test_latency4();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
